// File: rtl/sign_extender.sv
// -----------------------------------------------------------------------------
// sign_extender
//
// Immediate generator for the single-cycle RV32I datapath. The decoder hands
// over a 20-bit raw immediate field. The control unit supplies the operation
// code. This block forms the 32-bit immediate that the ALU, branch and PC logic
// consume. The result is registered, so it has exactly one clock of latency.
//
// Ports:
//    clk    - system clock, rising-edge active
//    rst    - synchronous reset, active-high; clears immOut on the edge
//    imm    - 20-bit raw immediate field from the decoder
//    CUOp   - 6-bit control-unit operation code
//    immOut - 32-bit registered extended immediate
// -----------------------------------------------------------------------------
module sign_extender (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] imm,
   input  logic [5:0]  CUOp,
   output logic [31:0] immOut
);

   // Control-unit operation codes. Codes 39..63 are unused.
   typedef enum logic [5:0] {
      OP_LUI   = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL   = 6'd2,  OP_JALR  = 6'd3,
      OP_BEQ   = 6'd4,  OP_BNE   = 6'd5,  OP_BLT   = 6'd6,  OP_BGE   = 6'd7,
      OP_BLTU  = 6'd8,  OP_BGEU  = 6'd9,
      OP_LB    = 6'd10, OP_LH    = 6'd11, OP_LW    = 6'd12, OP_LBU   = 6'd13,
      OP_LHU   = 6'd14,
      OP_SB    = 6'd15, OP_SH    = 6'd16, OP_SW    = 6'd17,
      OP_ADDI  = 6'd18, OP_SLTI  = 6'd19, OP_SLTIU = 6'd20, OP_SLIU  = 6'd21,
      OP_XORI  = 6'd22, OP_ORI   = 6'd23, OP_ANDI  = 6'd24, OP_SLLI  = 6'd25,
      OP_SRLI  = 6'd26, OP_SRAI  = 6'd27,
      OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31,
      OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35,
      OP_OR    = 6'd36, OP_AND   = 6'd37,
      OP_ERROR = 6'd38
   } cu_op_e;

   cu_op_e      op;
   logic [31:0] ext_imm;

   assign op = cu_op_e'(CUOp);

   // Select the immediate format from the operation class.
   always_comb begin
      ext_imm = 32'h0000_0000;
      case (op)
         // U-type: field occupies the upper 20 bits.
         OP_LUI, OP_AUIPC: begin
            ext_imm = {imm, 12'h000};
         end
         // J-type: the decoder packs the sign in imm[19]. Rotating the field left
         // by one puts the offset in place with bit 0 carrying the sign copy.
         OP_JAL: begin
            ext_imm = {{12{imm[19]}}, imm[18:0], imm[19]};
         end
         // B-type: same rotate trick on the 12-bit field; imm[19:12] ignored.
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            ext_imm = {{20{imm[11]}}, imm[10:0], imm[11]};
         end
         // I-type, including loads, JALR and the immediate shifts.
         OP_JALR,
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
         OP_ADDI, OP_SLTI, OP_SLTIU, OP_SLIU, OP_XORI, OP_ORI, OP_ANDI,
         OP_SLLI, OP_SRLI, OP_SRAI: begin
            ext_imm = {{20{imm[11]}}, imm[11:0]};
         end
         // S-type: plain sign extension of the whole 20-bit field.
         OP_SB, OP_SH, OP_SW: begin
            ext_imm = {{12{imm[19]}}, imm};
         end
         // R-type, ERROR and unused codes carry no immediate.
         default: begin
            ext_imm = 32'h0000_0000;
         end
      endcase
   end

   // Output register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         immOut <= 32'h0000_0000;
      end else begin
         immOut <= ext_imm;
      end
   end

endmodule

// File: tb/tb_sign_extender.sv
// -----------------------------------------------------------------------------
// tb_sign_extender
//
// Directed-vector bench for sign_extender. Inputs change on the falling edge.
// The registered output is sampled 1 ns after the rising edge and compared
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_sign_extender;

   logic        clk;
   logic        rst;
   logic [19:0] imm;
   logic [5:0]  CUOp;
   logic [31:0] immOut;

   int passed;
   int total;

   localparam logic [5:0] C_LUI   = 6'd0;
   localparam logic [5:0] C_AUIPC = 6'd1;
   localparam logic [5:0] C_JAL   = 6'd2;
   localparam logic [5:0] C_JALR  = 6'd3;
   localparam logic [5:0] C_BLT   = 6'd6;
   localparam logic [5:0] C_BGEU  = 6'd9;
   localparam logic [5:0] C_LH    = 6'd11;
   localparam logic [5:0] C_SH    = 6'd16;
   localparam logic [5:0] C_SW    = 6'd17;
   localparam logic [5:0] C_ADDI  = 6'd18;
   localparam logic [5:0] C_SLIU  = 6'd21;
   localparam logic [5:0] C_SRAI  = 6'd27;
   localparam logic [5:0] C_ADD   = 6'd28;
   localparam logic [5:0] C_AND   = 6'd37;
   localparam logic [5:0] C_ERROR = 6'd38;

   sign_extender dut (
      .clk    (clk),
      .rst    (rst),
      .imm    (imm),
      .CUOp   (CUOp),
      .immOut (immOut)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report a mismatch.
   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      total = total + 1;
      if (got === exp) begin
         passed = passed + 1;
      end else begin
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Drive one input pair, clock it in, then compare the registered result.
   task automatic apply(input string tag, input logic [5:0] op,
                        input logic [19:0] val, input logic [31:0] exp);
      @(negedge clk);
      CUOp = op;
      imm  = val;
      @(posedge clk);
      #1;
      check_value(tag, immOut, exp);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst    = 1'b1;
      imm    = 20'hCCCCC;
      CUOp   = C_LUI;

      // Reset edge clears the output; release gives the LUI result next edge.
      @(posedge clk);
      #1;
      check_value("reset", immOut, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_value("lui_after_reset", immOut, 32'hCCCC_C000);

      // U-type
      apply("auipc", C_AUIPC, 20'h12345, 32'h1234_5000);
      // B-type
      apply("blt_neg",  C_BLT,  20'hCCCCC, 32'hFFFF_F999);
      apply("blt_pos",  C_BLT,  20'h00555, 32'h0000_0AAA);
      apply("bgeu_upper_ignored", C_BGEU, 20'hFF7FF, 32'h0000_0FFE);
      // J-type
      apply("jal_neg",  C_JAL,  20'hCCCCC, 32'hFFF9_9999);
      apply("jal_pos",  C_JAL,  20'h4CCCC, 32'h0009_9998);
      // I-type
      apply("lh_neg",   C_LH,   20'hCCCCC, 32'hFFFF_FCCC);
      apply("addi_upper_ignored", C_ADDI, 20'hFF7FF, 32'h0000_07FF);
      apply("jalr_neg", C_JALR, 20'h00800, 32'hFFFF_F800);
      apply("sliu",     C_SLIU, 20'h0F00F, 32'h0000_000F);
      apply("srai",     C_SRAI, 20'hABC85, 32'hFFFF_FC85);
      // S-type
      apply("sh_neg",   C_SH,   20'hCCCCC, 32'hFFFC_CCCC);
      apply("sw_pos",   C_SW,   20'h7FFFF, 32'h0007_FFFF);
      // Zero classes, back to back
      apply("add_zero",    C_ADD,   20'hFFFFF, 32'h0000_0000);
      apply("error_zero",  C_ERROR, 20'hFFFFF, 32'h0000_0000);
      apply("unused_zero", 6'd50,   20'hFFFFF, 32'h0000_0000);
      apply("and_zero",    C_AND,   20'hFFFFF, 32'h0000_0000);
      apply("code63_zero", 6'd63,   20'hFFFFF, 32'h0000_0000);

      // Alternate LUI/JAL each cycle. The output holds the previous result
      // until the edge that samples the new inputs.
      apply("alt_lui0", C_LUI, 20'hCCCCC, 32'hCCCC_C000);
      @(negedge clk);
      check_value("alt_hold0", immOut, 32'hCCCC_C000);
      CUOp = C_JAL;
      imm  = 20'hCCCCC;
      @(posedge clk);
      #1;
      check_value("alt_jal0", immOut, 32'hFFF9_9999);
      @(negedge clk);
      check_value("alt_hold1", immOut, 32'hFFF9_9999);
      CUOp = C_LUI;
      imm  = 20'h00001;
      @(posedge clk);
      #1;
      check_value("alt_lui1", immOut, 32'h0000_1000);
      apply("alt_jal1", C_JAL, 20'h4CCCC, 32'h0009_9998);

      // Reset mid-stream overrides a valid operation.
      @(negedge clk);
      rst  = 1'b1;
      CUOp = C_SH;
      imm  = 20'hCCCCC;
      @(posedge clk);
      #1;
      check_value("mid_reset", immOut, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_value("first_after_mid_reset", immOut, 32'hFFFC_CCCC);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sign_extender.md
Name: sign_extender

Overview:
- Immediate generator for the single-cycle RV32I datapath.
- Takes the 20-bit raw immediate field extracted by the decoder, plus the control-unit operation code (cuOPType).
- Produces the 32-bit immediate consumed by the ALU, branch and PC logic.
- Output is registered: one clock of latency, synchronous active-high reset.

Parameters:
- None. Widths fixed: imm 20, immOut 32, CUOp 6.

Ports:
- clk    input   1   system clock, rising-edge active
- rst    input   1   synchronous reset, active-high
- imm    input   20  raw immediate field from decoder
- CUOp   input   6   cuOPType operation code
- immOut output  32  registered extended immediate

Behaviour:
- Single clock `clk`; reset `rst` is synchronous and active-high.
- While rst=1 at a rising edge: immOut <= 32'h0000_0000 on that edge. rst overrides all other inputs.
- Otherwise, at each rising edge immOut <= f(CUOp, imm), where f is purely combinational. Latency is exactly 1 cycle; no handshake, no stall.
- cuOPType encoding, decimal:
  - LUI=0, AUIPC=1, JAL=2, JALR=3
  - BEQ=4, BNE=5, BLT=6, BGE=7, BLTU=8, BGEU=9
  - LB=10, LH=11, LW=12, LBU=13, LHU=14
  - SB=15, SH=16, SW=17
  - ADDI=18, SLTI=19, SLTIU=20, SLIU=21, XORI=22, ORI=23, ANDI=24, SLLI=25, SRLI=26, SRAI=27
  - ADD=28, SUB=29, SLL=30, SLT=31, SLTU=32, XOR=33, SRL=34, SRA=35, OR=36, AND=37
  - ERROR=38
- f by class:
  - U (LUI, AUIPC): {imm[19:0], 12'b0}.
  - J (JAL): {{12{imm[19]}}, imm[18:0], imm[19]}. The 20-bit field is rotated left by 1; its MSB is the sign and is replicated into bits 31:20.
  - B (BEQ..BGEU): {{20{imm[11]}}, imm[10:0], imm[11]}. imm[19:12] ignored.
  - I (JALR, LB..LHU, ADDI..SRAI including shifts and SLIU): {{20{imm[11]}}, imm[11:0]}. imm[19:12] ignored.
  - S (SB, SH, SW): {{12{imm[19]}}, imm[19:0]}, i.e. plain 20-bit sign extension.
  - R-type (28..37), ERROR (38), unused codes 39..63: 32'h0.
- Sign source is always the MSB of the selected field. Zero-valued sign bits give zero upper bits; no unsigned variants.
- CUOp and imm may change every cycle; each edge samples the current pair independently, with no history.
- Reset mid-stream: the output clears on the reset edge. The first post-reset result appears on the first edge with rst=0.

Test Plan:
- Reset: imm=20'hCCCCC, CUOp=LUI, rst=1 for one edge -> immOut=32'h0; release rst, next edge -> 32'hCCCCC000.
- B-type: CUOp=BLT, imm=20'hCCCCC -> after one edge immOut=32'hFFFFF999; imm=20'h00555 -> 32'h00000AAA.
- J-type: CUOp=JAL, imm=20'hCCCCC -> 32'hFFF99999; imm=20'h4CCCC -> 32'h00099998.
- I-type: CUOp=LH, imm=20'hCCCCC -> 32'hFFFFFCCC; CUOp=ADDI, imm=20'hFF7FF -> 32'h000007FF (upper field bits ignored).
- S-type: CUOp=SH, imm=20'hCCCCC -> 32'hFFFCCCCC; CUOp=SW, imm=20'h7FFFF -> 32'h0007FFFF.
- Zero cases and back-to-back: CUOp=ADD then ERROR then 6'd50 with imm=20'hFFFFF -> 32'h0 each cycle. Alternate LUI/JAL on consecutive edges -> each result appears exactly one cycle after its inputs.
